sp_sram: RTL and testbench

Parametrised single-port synchronous SRAM with chip-select, byte-write enables, configurable read latency, out-of-range detection and an optional post-reset zero-fill sweep. It is the next generation of the lab's small behavioural RAM: fully clocked, no level-sensitive access, with a `ready`/`rd_valid` handshake so a controller or testbench can stream back-to-back accesses.

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_array.sv | 44 ++++
 rtl/sp_sram.sv | 127 ++++++++++++
 tb/tb_sp_sram.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the sp_sram single-port RAM and its storage array.
package sram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int byte_lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/sram_array.sv
// DEPTH x DATA_W storage with a byte-masked synchronous write and a registered read.
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we_i,
  input  logic [AW-1:0]                 waddr_i,
  input  logic [byte_lanes(DATA_W)-1:0] wbe_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic                          re_i,
  input  logic [AW-1:0]                 raddr_i,
  input  logic                          rzero_i,
  output logic [DATA_W-1:0]             rdata_o
);
  localparam int NB = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe_i[i]) mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read register doubles as the latency-1 output, so it must clear on reset and hold between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sp_sram.sv
// Single-port synchronous SRAM: zero-fill sweep FSM, range check, byte writes, 1/2-cycle reads.
module sp_sram
  import sram_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 1024,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          wr,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [byte_lanes(DATA_W)-1:0] be,
  input  logic [DATA_W-1:0]             d_in,
  output logic                          ready,
  output logic [DATA_W-1:0]             d_out,
  output logic                          rd_valid,
  output logic                          err
);
  localparam int NB = byte_lanes(DATA_W);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_q, clr_d;
  logic            ready_q, ready_d;

  logic            acc, in_rng, sweep_we;
  logic            arr_we, arr_re;
  logic [AW-1:0]   arr_waddr;
  logic [NB-1:0]   arr_wbe;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic            rd_vld_p1_q, err_p1_q;

  assign acc      = cs & ready_q;
  assign in_rng   = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  assign sweep_we = (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0) && !rst;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    ready_d = ready_q;
    if (state_q == ST_CLEAR) begin
      if ((CLEAR_ON_RESET == 0) || (clr_q == AW'(DEPTH - 1))) begin
        state_d = ST_READY;
        ready_d = 1'b1;
      end else begin
        clr_d = clr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ready_q <= ready_d;
    end
  end

  // The sweep owns the write port while ready is low, so it never collides with a user write.
  assign arr_we    = sweep_we | (acc & wr & in_rng);
  assign arr_waddr = sweep_we ? clr_q : addr[AW-1:0];
  assign arr_wbe   = sweep_we ? '1 : be;
  assign arr_wdata = sweep_we ? '0 : d_in;
  assign arr_re    = acc & ~wr;

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wbe_i   (arr_wbe),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .raddr_i (addr[AW-1:0]),
    .rzero_i (~in_rng),
    .rdata_o (arr_rdata)
  );

  // Stage p1: read strobe and range error, one cycle after accept
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p1_q <= 1'b0;
      err_p1_q    <= 1'b0;
    end else begin
      rd_vld_p1_q <= arr_re;
      err_p1_q    <= acc & ~in_rng;
    end
  end

  assign ready = ready_q;
  assign err   = err_p1_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] dout_p2_q;
      logic              rd_vld_p2_q;
      // Stage p2: optional output register
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_vld_p2_q <= 1'b0;
          dout_p2_q   <= '0;
        end else begin
          rd_vld_p2_q <= rd_vld_p1_q;
          if (rd_vld_p1_q) dout_p2_q <= arr_rdata;
        end
      end
      assign d_out    = dout_p2_q;
      assign rd_valid = rd_vld_p2_q;
    end else begin : g_no_out_reg
      assign d_out    = arr_rdata;
      assign rd_valid = rd_vld_p1_q;
    end
  endgenerate

endmodule

// File: tb/tb_sp_sram.sv
// Bench for sp_sram: latency-1 and latency-2 instances share stimulus and a behavioural model.
module tb_sp_sram;
  localparam int DEPTH = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, wr = 1'b0;
  logic [5:0]  addr = '0;
  logic [1:0]  be = '0;
  logic [15:0] d_in = '0;

  logic        ready0, rv0, err0, ready1, rv1, err1;
  logic [15:0] do0, do1;

  int errors = 0;
  int checks = 0;

  sp_sram #(.ADDR_W(6), .DATA_W(16), .DEPTH(DEPTH), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .addr(addr), .be(be), .d_in(d_in),
    .ready(ready0), .d_out(do0), .rd_valid(rv0), .err(err0));

  sp_sram #(.ADDR_W(6), .DATA_W(16), .DEPTH(DEPTH), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .addr(addr), .be(be), .d_in(d_in),
    .ready(ready1), .d_out(do1), .rd_valid(rv1), .err(err1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory array, ready countdown and a one-deep delay for the latency-2 output.
  logic [15:0] mm [0:63];
  bit          chk_en = 0;
  bit          m_rdy, pv;
  int          sweep;
  logic [15:0] pval;
  logic        exp_ready, exp_rv0, exp_rv1, exp_err;
  logic [15:0] exp_do0, exp_do1;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_rdy = 0; sweep = 0; pv = 0;
      exp_ready = 0; exp_rv0 = 0; exp_rv1 = 0; exp_err = 0;
      exp_do0 = '0; exp_do1 = '0;
      chk_en = 1;
    end else begin
      exp_rv1 = pv;
      if (pv) exp_do1 = pval;
      exp_rv0 = 0; exp_err = 0; pv = 0;
      if (cs && m_rdy) begin
        exp_err = (addr >= DEPTH);
        if (wr) begin
          if (addr < DEPTH)
            for (int i = 0; i < 2; i++)
              if (be[i]) mm[addr][8*i +: 8] = d_in[8*i +: 8];
        end else begin
          pval = (addr < DEPTH) ? mm[addr] : 16'h0000;
          exp_rv0 = 1; exp_do0 = pval; pv = 1;
        end
      end
      if (!m_rdy) begin
        mm[sweep] = '0;
        sweep++;
        if (sweep == DEPTH) m_rdy = 1;
      end
      exp_ready = m_rdy;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ready0", ready0, exp_ready);
      chk("ready1", ready1, exp_ready);
      chk("rd_valid0", rv0, exp_rv0);
      chk("rd_valid1", rv1, exp_rv1);
      chk("err0", err0, exp_err);
      chk("err1", err1, exp_err);
      chk("d_out0", do0, exp_do0);
      chk("d_out1", do1, exp_do1);
    end
  end

  task automatic acc(input bit w, input logic [5:0] a, input logic [1:0] b, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; wr = w; addr = a; be = b; d_in = d;
  endtask

  task automatic rd_lit(input logic [5:0] a, input logic [15:0] e);
    acc(1'b0, a, 2'b00, 16'h0);
    @(negedge clk);
    cs = 1'b0;
    chk("lit_rv0", rv0, 1'b1);
    chk("lit_do0", do0, e);
    @(negedge clk);
    chk("lit_rv1", rv1, 1'b1);
    chk("lit_do1", do1, e);
  endtask

  // Counts cycles with rst low and ready low, starting with the release cycle; cs is exercised meanwhile.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready0 && n < 200) begin
      n++;
      cs = 1'b1; wr = 1'($urandom); addr = 6'($urandom); be = 2'($urandom); d_in = 16'($urandom);
      @(negedge clk);
    end
    cs = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ready0, 1'b0);
    chk("rst_dout0", do0, 16'h0);
    chk("rst_dout1", do1, 16'h0);
    chk("rst_rv", rv1, 1'b0);
    rst = 1'b0;
    wait_ready(n);
    chk("ready_low_cycles", n, 50);

    for (int k = 0; k < DEPTH; k++) rd_lit(6'(k), 16'h0000);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_ready(n);
    chk("restart_low_cycles", n, 50);

    for (int k = 0; k < DEPTH; k++) acc(1'b1, 6'(k), 2'b11, 16'(2*k));
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 1) chk("lat2_not_yet", rv1, 1'b0);
      if (i >= 1 && i <= 20) begin
        chk("stream_rv0", rv0, 1'b1);
        chk("stream_do0", do0, 16'(2*(i-1)));
      end
      if (i >= 2) begin
        chk("stream_rv1", rv1, 1'b1);
        chk("stream_do1", do1, 16'(2*(i-2)));
      end
      if (i < 20) begin
        cs = 1'b1; wr = 1'b0; addr = 6'(i);
      end else cs = 1'b0;
    end

    acc(1'b1, 6'd5, 2'b11, 16'hAAAA);
    acc(1'b1, 6'd5, 2'b01, 16'h1234);
    rd_lit(6'd5, 16'hAA34);

    acc(1'b1, 6'd50, 2'b11, 16'hFFFF);
    @(negedge clk); cs = 1'b0;
    chk("oor_wr_err0", err0, 1'b1);
    chk("oor_wr_err1", err1, 1'b1);
    acc(1'b0, 6'd50, 2'b00, 16'h0);
    @(negedge clk); cs = 1'b0;
    chk("oor_rd_err0", err0, 1'b1);
    chk("oor_rd_err1", err1, 1'b1);
    chk("oor_rd_rv0", rv0, 1'b1);
    chk("oor_rd_do0", do0, 16'h0);
    @(negedge clk);
    chk("oor_rd_rv1", rv1, 1'b1);
    chk("oor_rd_do1", do1, 16'h0);
    for (int k = 0; k < DEPTH; k++) rd_lit(6'(k), (k == 5) ? 16'hAA34 : 16'(2*k));

    acc(1'b0, 6'd3, 2'b00, 16'h0);
    @(negedge clk); cs = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("kill_rv1", rv1, 1'b0);
    chk("kill_do1", do1, 16'h0);
    rst = 1'b0;
    wait_ready(n);
    chk("post_kill_low_cycles", n, 50);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 999) == 0);
      cs   = 1'($urandom);
      wr   = 1'($urandom);
      addr = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(50, 63)) : 6'($urandom_range(0, 49));
      be   = 2'($urandom);
      d_in = 16'($urandom);
    end
    @(negedge clk);
    cs = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
